// File: rtl/lvl_seq_pkg.sv
// Shared types and default constants for the level sequencer.
//   state_t          : IDLE / PLAY / WIN
//   *_DEF constants  : default tick base, per-level step, level count, buzzer length
//   LVL_W            : width of the level output
package lvl_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        WIN  = 2'd2
    } state_t;

    localparam int unsigned TICK_BASE_DEF  = 25000000;
    localparam int unsigned TICK_STEP_DEF  = 1562500;
    localparam int unsigned NUM_LVL_DEF    = 8;
    localparam int unsigned BUZ_CYCLES_DEF = 50000000;
    localparam int unsigned LVL_W          = 4;

endpackage

// File: rtl/level_sequencer_rise_det.sv
// Registered rising-edge detector for a level input (button or event line).
// The delayed copy is registered every cycle; the rise flag is combinational.
//   clkin    : system clock
//   reset    : synchronous, active-high; clears the delayed copy
//   i_sig    : sampled level
//   o_rise_c : high in any cycle where i_sig is 1 and was 0 on the previous edge
module rise_det (
    input  logic clkin,
    input  logic reset,
    input  logic i_sig,
    output logic o_rise_c
);

    logic r_sig_q;

    always_ff @(posedge clkin) begin
        if (reset) begin
            r_sig_q <= 1'b0;
        end else begin
            r_sig_q <= i_sig;
        end
    end

    assign o_rise_c = i_sig & ~r_sig_q;

endmodule

// File: rtl/level_sequencer.sv
// Game-speed controller: issues one-cycle tick enables whose period shrinks
// with the level, advances the level on each wave-cleared rising edge, and
// drives the win buzzer for BUZ_CYCLES cycles after the final level.
//   clkin    : system clock
//   reset    : synchronous, active-high
//   start    : begin play from IDLE (level-sensitive)
//   wave_clr : wave cleared; only its rising edge counts
//   pause    : (only with LVL_SEQ_PAUSE_EN) freezes counting and wave edges in PLAY
//   tick     : one-cycle game-step enable (a clock enable, never a clock)
//   level    : current level, 1..NUM_LVL
//   playing  : high while in PLAY
//   buz      : win buzzer drive
//   win      : one-cycle pulse on entry to WIN
// Optional feature macro: LVL_SEQ_PAUSE_EN.
module level_sequencer
    import lvl_seq_pkg::*;
#(
    parameter int unsigned TICK_BASE  = TICK_BASE_DEF,
    parameter int unsigned TICK_STEP  = TICK_STEP_DEF,
    parameter int unsigned NUM_LVL    = NUM_LVL_DEF,
    parameter int unsigned BUZ_CYCLES = BUZ_CYCLES_DEF
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             start,
    input  logic             wave_clr,
`ifdef LVL_SEQ_PAUSE_EN
    input  logic             pause,
`endif
    output logic             tick,
    output logic [LVL_W-1:0] level,
    output logic             playing,
    output logic             buz,
    output logic             win
);

    localparam int unsigned CNT_W = (TICK_BASE > 2)  ? $clog2(TICK_BASE)  : 1;
    localparam int unsigned BUZ_W = (BUZ_CYCLES > 2) ? $clog2(BUZ_CYCLES) : 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [LVL_W-1:0]   r_level;
    logic [LVL_W-1:0]   w_level_nxt;
    logic [BUZ_W-1:0]   r_buz_cnt;
    logic [BUZ_W-1:0]   w_buz_cnt_nxt;
    logic               r_tick;
    logic               w_tick_nxt;
    logic               r_buz;
    logic               w_buz_nxt;
    logic               r_win;
    logic               w_win_nxt;
    logic               r_playing;
    logic               w_pause;
    logic               w_wclr_rise;
    logic [31:0]        w_limit;
    logic               w_cnt_term;
    logic               w_buz_term;
    logic               w_last_lvl;

`ifdef LVL_SEQ_PAUSE_EN
    assign w_pause = pause;
`else
    assign w_pause = 1'b0;
`endif

    // Wave-cleared edge detector; its register updates in every state.
    rise_det u_wclr_det (
        .clkin    (clkin),
        .reset    (reset),
        .i_sig    (wave_clr),
        .o_rise_c (w_wclr_rise)
    );

    // Tick period for the current level.
    assign w_limit    = TICK_BASE - (32'(r_level) - 32'd1) * TICK_STEP;
    assign w_cnt_term = (r_cnt == CNT_W'(w_limit - 32'd1));
    assign w_buz_term = (r_buz_cnt == BUZ_W'(BUZ_CYCLES - 32'd1));
    assign w_last_lvl = (r_level >= LVL_W'(NUM_LVL));

    // State and registered outputs.
    always_ff @(posedge clkin) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_level   <= LVL_W'(1);
            r_buz_cnt <= '0;
            r_tick    <= 1'b0;
            r_buz     <= 1'b0;
            r_win     <= 1'b0;
            r_playing <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_level   <= w_level_nxt;
            r_buz_cnt <= w_buz_cnt_nxt;
            r_tick    <= w_tick_nxt;
            r_buz     <= w_buz_nxt;
            r_win     <= w_win_nxt;
            r_playing <= (w_state_nxt == PLAY);
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_level_nxt   = r_level;
        w_buz_cnt_nxt = r_buz_cnt;
        w_tick_nxt    = 1'b0;
        w_buz_nxt     = 1'b0;
        w_win_nxt     = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = PLAY;
                    w_cnt_nxt   = '0;
                    w_level_nxt = LVL_W'(1);
                end
            end

            PLAY: begin
                if (!w_pause) begin
                    // A wave edge beats the terminal count: restart, no tick.
                    if (w_wclr_rise) begin
                        w_cnt_nxt = '0;
                        if (!w_last_lvl) begin
                            w_level_nxt = r_level + LVL_W'(1);
                        end else begin
                            w_state_nxt   = WIN;
                            w_buz_nxt     = 1'b1;
                            w_win_nxt     = 1'b1;
                            w_buz_cnt_nxt = '0;
                        end
                    end else if (w_cnt_term) begin
                        w_cnt_nxt  = '0;
                        w_tick_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end

            WIN: begin
                if (w_buz_term) begin
                    w_state_nxt   = IDLE;
                    w_level_nxt   = LVL_W'(1);
                    w_buz_cnt_nxt = '0;
                end else begin
                    w_buz_nxt     = 1'b1;
                    w_buz_cnt_nxt = r_buz_cnt + BUZ_W'(1);
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_level_nxt = LVL_W'(1);
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign tick    = r_tick;
    assign level   = r_level;
    assign playing = r_playing;
    assign buz     = r_buz;
    assign win     = r_win;

endmodule

// File: doc/level_sequencer.md
Name: level_sequencer

Overview:
- Game-speed controller for the Space Invaders datapath.
- Emits one-cycle `tick` enables whose period shrinks as the level rises.
- Advances the level on each wave-cleared event and sequences the win buzzer after the final level.
- Replaces free-running level logic: the movement/render logic consumes `tick` as a clock enable on `clkin` and never as a derived clock.

Parameters:
- TICK_BASE, 25000000, tick period in `clkin` cycles at level 1
- TICK_STEP, 1562500, period reduction per level increment
- NUM_LVL, 8, number of levels (1..15); constraint TICK_BASE-(NUM_LVL-1)*TICK_STEP >= 2
- BUZ_CYCLES, 50000000, buzzer-on duration in cycles after the final level is cleared

Ports:
- clkin  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  level-sensitive request to begin play from IDLE
- wave_clr  in  1  wave cleared; may be held high many cycles, only its rising edge counts
- tick  out  1  one-cycle game-step enable
- level  out  4  current level, 1..NUM_LVL
- playing  out  1  high while state==PLAY
- buz  out  1  win buzzer drive
- win  out  1  one-cycle pulse on entry to WIN

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clkin.
- Reset dominates every other input. On the edge where reset==1:
  - state=IDLE, level=1, cnt=0, buz_cnt=0.
  - tick=0, playing=0, buz=0, win=0.
  - The edge-detect register for wave_clr is loaded with 0.
- Period: limit = TICK_BASE-(level-1)*TICK_STEP, computed combinationally. cnt width = $clog2(TICK_BASE).
- Edge detection: wclr_rise = wave_clr & ~wave_clr_q. wave_clr_q is registered every cycle in every state.
- IDLE:
  - tick=0, buz=0.
  - start==1 → PLAY on the next edge, with cnt=0 and level=1.
  - wave_clr is ignored.
- PLAY (playing=1):
  - Default: cnt increments each cycle.
  - When cnt==limit-1 and there is no wclr_rise: cnt←0 and tick←1 for the following cycle. Ticks are therefore exactly limit cycles apart, and the first tick is high limit cycles after the edge that entered PLAY.
  - wclr_rise with level<NUM_LVL: level←level+1 and cnt←0.
  - wclr_rise with level==NUM_LVL: → WIN, with buz←1, win←1 for one cycle, and buz_cnt←0.
  - wclr_rise has priority over the tick terminal count. In that same cycle no tick is issued and cnt←0.
  - start is ignored.
- WIN:
  - tick=0, playing=0, buz=1; buz_cnt increments each cycle.
  - When buz_cnt==BUZ_CYCLES-1: buz←0, level←1, state←IDLE. buz is high for exactly BUZ_CYCLES cycles.
  - start and wave_clr are ignored.
- Reset mid-operation in any state: reset values take effect on the next edge. No tick or buz glitch survives it.
- level never wraps to 0 and never exceeds NUM_LVL.

Optional Feature:
- Macro: LVL_SEQ_PAUSE_EN.
- Defined:
  - Adds input `pause` (1 bit).
  - While pause==1 in PLAY: cnt holds, tick=0, and wclr_rise is ignored. wave_clr_q still updates, so an edge that occurs during pause is lost.
  - When pause drops, counting resumes from the held cnt.
- Undefined: the port is absent and behaviour equals pause==0.

Decomposition:
- Package lvl_seq_pkg:
  - state enum {IDLE, PLAY, WIN}.
  - Default constants TICK_BASE_DEF, TICK_STEP_DEF, NUM_LVL_DEF, BUZ_CYCLES_DEF.
  - LVL_W=4.
- One natural sub-module: `rise_det`, a registered rising-edge detector for wave_clr, reusable by other button inputs.
- Period counter and FSM stay in level_sequencer.

Test Plan:
All scenarios use TICK_BASE=10, TICK_STEP=2, NUM_LVL=3, BUZ_CYCLES=5.
1. Reset, then start=1 for 1 cycle → playing=1, level=1; first tick 10 cycles after PLAY entry, then every 10 cycles, each 1 cycle wide.
2. In PLAY at level 1, one wave_clr pulse → level=2, cnt restarts; next tick 8 cycles later, then every 8.
3. wave_clr held high 30 cycles at level 1 → exactly one advance (level=2); after release and a new pulse → level=3, ticks every 6.
4. At level 3, wave_clr pulse → win pulse 1 cycle, buz=1 for exactly 5 cycles, no ticks; then IDLE, level=1, playing=0. start during WIN is ignored.
5. wave_clr rises in the same cycle as cnt==limit-1 at level 1 → no tick that cycle, level=2, next tick 8 cycles later.
6. reset=1 during WIN (buz=1) and during PLAY at level 2 → next edge buz=0, tick=0, level=1, state IDLE. With LVL_SEQ_PAUSE_EN, pause=1 for 20 cycles at cnt=4 → no ticks; tick 6 cycles after release.
